// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared encodings for the load/store stage: load/store/Memtoreg control
// encodings, the LSU FSM state type and the data-memory byte-enable constants.
package lsu_pkg;

  // Load control encodings (110 and 111 behave as no load)
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  // Store control encodings
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  // Writeback select: only this value picks load data
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

  // Byte-enable patterns
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } lsu_state_t;

  // True only for the five real load encodings
  function automatic logic is_load(input logic [2:0] ld);
    return (ld != LD_NONE) && (ld <= LD_LHU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align
// Combinational load-data alignment: picks the byte/halfword lane named by the
// low address bits and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata   in  32  raw word returned by data memory
//   addr_lo in  2   low address bits latched at grant
//   ld_type in  3   latched load type
//   data    out 32  aligned, extended load data
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'b0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'b0, half_sel};
      LD_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu
// Load/store stage: issues data-memory requests for the instruction held in the
// execute registers, stalls upstream while an access is outstanding, aligns load
// data and registers the writeback record.
// Optional feature: define LSU_MISALIGN_TRAP_EN to suppress misaligned accesses
// and flag them on lsu_misalign; otherwise low address bits are ignored.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_result, Rd2_exe2lsu       address / writeback data, store data
//   Memtoreg/Ld_cntr/St_cntr      writeback select, load type, store type
//   RegW/wr_addr_exe2lsu          write enable and destination register
//   dmem_*                        data-memory request/response handshake
//   lsu_stall                     hold execute outputs stable
//   wb_data/RegW/wr_addr_lsu2wb   registered writeback record
//   lsu_misalign                  registered misaligned-access flag
module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] Rd2_exe2lsu,
  input  logic [1:0]       Memtoreg_exe2lsu,
  input  logic [2:0]       Ld_cntr_exe2lsu,
  input  logic [1:0]       St_cntr_exe2lsu,
  input  logic             RegW_exe2lsu,
  input  logic [4:0]       wr_addr_exe2lsu,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             lsu_stall,
  output logic [WIDTH-1:0] wb_data,
  output logic             RegW_lsu2wb,
  output logic [4:0]       wr_addr_lsu2wb,
  output logic             lsu_misalign
);

  lsu_state_t state, next_state;

  logic        ld_op, st_op, misalign_now, issue;
  logic [1:0]  lat_addr_lo;
  logic [2:0]  lat_ld;
  logic [4:0]  lat_wr_addr;
  logic        lat_regw;
  logic [31:0] load_data;

  assign ld_op = is_load(Ld_cntr_exe2lsu);
  assign st_op = (St_cntr_exe2lsu != ST_NONE);

`ifdef LSU_MISALIGN_TRAP_EN
  // Classify the winning operation (load beats store) against its natural alignment.
  always_comb begin
    misalign_now = 1'b0;
    if (ld_op) begin
      case (Ld_cntr_exe2lsu)
        LD_LH, LD_LHU: misalign_now = alu_result[0];
        LD_LW:         misalign_now = |alu_result[1:0];
        default:       misalign_now = 1'b0;
      endcase
    end else if (st_op) begin
      case (St_cntr_exe2lsu)
        ST_SH:   misalign_now = alu_result[0];
        ST_SW:   misalign_now = |alu_result[1:0];
        default: misalign_now = 1'b0;
      endcase
    end
  end
`else
  assign misalign_now = 1'b0;
`endif

  assign issue = (ld_op || st_op) && !misalign_now;

  // State register plus the load context captured at grant, since upstream
  // may move on only after the response arrives but the lane info must be ours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_addr_lo <= 2'b00;
      lat_ld      <= LD_NONE;
      lat_wr_addr <= 5'd0;
      lat_regw    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && issue && ld_op && dmem_gnt) begin
        lat_addr_lo <= alu_result[1:0];
        lat_ld      <= Ld_cntr_exe2lsu;
        lat_wr_addr <= wr_addr_exe2lsu;
        lat_regw    <= RegW_exe2lsu;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (issue && ld_op && dmem_gnt) next_state = WAIT_RSP;
      WAIT_RSP: if (dmem_rvalid) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Request fields are forced to zero during reset so the memory sees nothing.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = BE_NONE;
    dmem_wdata = '0;
    lsu_stall  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (issue) begin
            dmem_req  = 1'b1;
            dmem_addr = {alu_result[WIDTH-1:2], 2'b00};
            lsu_stall = !dmem_gnt || ld_op;
            if (ld_op) begin
              dmem_be = BE_WORD;
            end else begin
              dmem_we = 1'b1;
              case (St_cntr_exe2lsu)
                ST_SB: begin
                  dmem_be    = BE_BYTE << alu_result[1:0];
                  dmem_wdata = {4{Rd2_exe2lsu[7:0]}};
                end
                ST_SH: begin
                  dmem_be    = alu_result[1] ? BE_HALF_HI : BE_HALF_LO;
                  dmem_wdata = {2{Rd2_exe2lsu[15:0]}};
                end
                default: begin
                  dmem_be    = BE_WORD;
                  dmem_wdata = Rd2_exe2lsu;
                end
              endcase
            end
          end
        end
        WAIT_RSP: lsu_stall = !dmem_rvalid;
        default:  lsu_stall = 1'b0;
      endcase
    end
  end

  lsu_load_align u_align (
    .rdata   (dmem_rdata),
    .addr_lo (lat_addr_lo),
    .ld_type (lat_ld),
    .data    (load_data)
  );

  // Writeback record: bubble by default, the current instruction when it
  // completes in IDLE, or the aligned load result on the response edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data        <= '0;
      RegW_lsu2wb    <= 1'b0;
      wr_addr_lsu2wb <= 5'd0;
      lsu_misalign   <= 1'b0;
    end else begin
      wb_data        <= '0;
      RegW_lsu2wb    <= 1'b0;
      wr_addr_lsu2wb <= 5'd0;
      lsu_misalign   <= 1'b0;
      case (state)
        IDLE: begin
          if (misalign_now) begin
            lsu_misalign <= 1'b1;
          end else if (!lsu_stall) begin
            wb_data        <= alu_result;
            RegW_lsu2wb    <= RegW_exe2lsu;
            wr_addr_lsu2wb <= wr_addr_exe2lsu;
          end
        end
        WAIT_RSP: begin
          if (dmem_rvalid) begin
            wb_data        <= (Memtoreg_exe2lsu == MEMTOREG_LOAD) ? load_data : alu_result;
            RegW_lsu2wb    <= lat_regw;
            wr_addr_lsu2wb <= lat_wr_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu
// Directed self-checking bench for the load/store stage.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, Rd2_exe2lsu, dmem_rdata;
  logic [1:0]  Memtoreg_exe2lsu, St_cntr_exe2lsu;
  logic [2:0]  Ld_cntr_exe2lsu;
  logic        RegW_exe2lsu, dmem_gnt, dmem_rvalid;
  logic [4:0]  wr_addr_exe2lsu;
  logic        dmem_req, dmem_we, lsu_stall, RegW_lsu2wb, lsu_misalign;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wr_addr_lsu2wb;

  int compareCount = 0;
  int failCount    = 0;

  always #5 clk = ~clk;

  lsu #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_result       (alu_result),
    .Rd2_exe2lsu      (Rd2_exe2lsu),
    .Memtoreg_exe2lsu (Memtoreg_exe2lsu),
    .Ld_cntr_exe2lsu  (Ld_cntr_exe2lsu),
    .St_cntr_exe2lsu  (St_cntr_exe2lsu),
    .RegW_exe2lsu     (RegW_exe2lsu),
    .wr_addr_exe2lsu  (wr_addr_exe2lsu),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (dmem_be),
    .dmem_wdata       (dmem_wdata),
    .dmem_gnt         (dmem_gnt),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .lsu_stall        (lsu_stall),
    .wb_data          (wb_data),
    .RegW_lsu2wb      (RegW_lsu2wb),
    .wr_addr_lsu2wb   (wr_addr_lsu2wb),
    .lsu_misalign     (lsu_misalign)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] rd2,
                               input logic [1:0] m2r, input logic [2:0] ld,
                               input logic [1:0] st, input logic regw, input logic [4:0] wra);
    alu_result       = alu;
    Rd2_exe2lsu      = rd2;
    Memtoreg_exe2lsu = m2r;
    Ld_cntr_exe2lsu  = ld;
    St_cntr_exe2lsu  = st;
    RegW_exe2lsu     = regw;
    wr_addr_exe2lsu  = wra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load granted immediately, answer it 'delay' cycles after grant.
  task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] ld,
                        input logic [31:0] rdata, input int delay, input logic [4:0] wra,
                        input logic [31:0] exp);
    logic [31:0] expAddr;
    expAddr = {addr[31:2], 2'b00};
    applyStimulus(addr, 32'h0, 2'b01, ld, 2'b00, 1'b1, wra);
    dmem_gnt = 1'b1;
    #1;
    checkOutput({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
    checkOutput({tag, "_addr"}, dmem_addr, expAddr);
    checkOutput({tag, "_be"}, {28'b0, dmem_be}, 32'hF);
    checkOutput({tag, "_stall_grant"}, {31'b0, lsu_stall}, 32'd1);
    tick();
    dmem_gnt = 1'b0;
    checkOutput({tag, "_bubble_grant"}, {31'b0, RegW_lsu2wb}, 32'd0);
    for (int i = 1; i < delay; i++) begin
      checkOutput({tag, "_wait_req"}, {31'b0, dmem_req}, 32'd0);
      checkOutput({tag, "_wait_stall"}, {31'b0, lsu_stall}, 32'd1);
      tick();
      checkOutput({tag, "_wait_bubble"}, {31'b0, RegW_lsu2wb}, 32'd0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    checkOutput({tag, "_stall_rvalid"}, {31'b0, lsu_stall}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    applyStimulus(32'h0, 32'h0, 2'b00, 3'b000, 2'b00, 1'b0, 5'd0);
    checkOutput({tag, "_wb_data"}, wb_data, exp);
    checkOutput({tag, "_wb_regw"}, {31'b0, RegW_lsu2wb}, 32'd1);
    checkOutput({tag, "_wb_addr"}, {27'b0, wr_addr_lsu2wb}, {27'b0, wra});
  endtask

  initial begin
    rst         = 1'b1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    // A store is presented during reset: the request must still read as idle.
    applyStimulus(32'h104, 32'hFFFFFFFF, 2'b00, 3'b000, 2'b11, 1'b1, 5'd3);
    tick();
    tick();
    checkOutput("rst_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("rst_we", {31'b0, dmem_we}, 32'd0);
    checkOutput("rst_be", {28'b0, dmem_be}, 32'd0);
    checkOutput("rst_addr", dmem_addr, 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_wb", wb_data, 32'd0);
    checkOutput("rst_regw", {31'b0, RegW_lsu2wb}, 32'd0);
    checkOutput("rst_wraddr", {27'b0, wr_addr_lsu2wb}, 32'd0);
    checkOutput("rst_mis", {31'b0, lsu_misalign}, 32'd0);
    rst = 1'b0;

    // Non-memory op
    applyStimulus(32'h1234, 32'h0, 2'b00, 3'b000, 2'b00, 1'b1, 5'd5);
    #1;
    checkOutput("alu_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("alu_stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    checkOutput("alu_wb", wb_data, 32'h1234);
    checkOutput("alu_regw", {31'b0, RegW_lsu2wb}, 32'd1);
    checkOutput("alu_wraddr", {27'b0, wr_addr_lsu2wb}, 32'd5);

    // sb at 0x103, grant delayed 2 cycles
    applyStimulus(32'h103, 32'hAABBCCDD, 2'b00, 3'b000, 2'b01, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      dmem_gnt = (i == 2);
      #1;
      checkOutput("sb_req", {31'b0, dmem_req}, 32'd1);
      checkOutput("sb_we", {31'b0, dmem_we}, 32'd1);
      checkOutput("sb_addr", dmem_addr, 32'h100);
      checkOutput("sb_be", {28'b0, dmem_be}, 32'h8);
      checkOutput("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
      checkOutput("sb_stall", {31'b0, lsu_stall}, (i < 2) ? 32'd1 : 32'd0);
      tick();
      checkOutput("sb_regw", {31'b0, RegW_lsu2wb}, 32'd0);
    end
    checkOutput("sb_wb", wb_data, 32'h103);
    dmem_gnt = 1'b0;

    // sh at 0x102 and sw at 0x104, granted at once
    applyStimulus(32'h102, 32'h11223344, 2'b00, 3'b000, 2'b10, 1'b0, 5'd0);
    dmem_gnt = 1'b1;
    #1;
    checkOutput("sh_be", {28'b0, dmem_be}, 32'hC);
    checkOutput("sh_wdata", dmem_wdata, 32'h33443344);
    checkOutput("sh_stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    applyStimulus(32'h104, 32'h11223344, 2'b00, 3'b000, 2'b11, 1'b0, 5'd0);
    #1;
    checkOutput("sw_be", {28'b0, dmem_be}, 32'hF);
    checkOutput("sw_wdata", dmem_wdata, 32'h11223344);
    checkOutput("sw_addr", dmem_addr, 32'h104);
    tick();
    dmem_gnt = 1'b0;

    // Loads
    doLoad("lb", 32'h102, 3'b001, 32'h00800000, 3, 5'd7, 32'hFFFFFF80);
    doLoad("lbu", 32'h102, 3'b100, 32'h00800000, 3, 5'd8, 32'h00000080);
    doLoad("lhu", 32'h102, 3'b101, 32'hBEEF1234, 1, 5'd9, 32'h0000BEEF);
    doLoad("lh", 32'h100, 3'b010, 32'h1234F00D, 1, 5'd10, 32'hFFFFF00D);
    doLoad("lw", 32'h100, 3'b011, 32'hBEEF1234, 2, 5'd11, 32'hBEEF1234);

    // Stray rvalid in IDLE must not disturb a non-memory op
    applyStimulus(32'h55, 32'h0, 2'b01, 3'b000, 2'b00, 1'b1, 5'd12);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("stray_wb", wb_data, 32'h55);
    checkOutput("stray_regw", {31'b0, RegW_lsu2wb}, 32'd1);

    // Reset while waiting for a load response
    applyStimulus(32'h100, 32'h0, 2'b01, 3'b011, 2'b00, 1'b1, 5'd13);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rstw_stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(32'h0, 32'h0, 2'b00, 3'b000, 2'b00, 1'b0, 5'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    #1;
    checkOutput("rstw_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("rstw_stall_idle", {31'b0, lsu_stall}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("rstw_wb", wb_data, 32'd0);
    checkOutput("rstw_regw", {31'b0, RegW_lsu2wb}, 32'd0);
    checkOutput("rstw_wraddr", {27'b0, wr_addr_lsu2wb}, 32'd0);

    // Misaligned word load at 0x101
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(32'h101, 32'h0, 2'b01, 3'b011, 2'b00, 1'b1, 5'd14);
    dmem_gnt = 1'b1;
    #1;
    checkOutput("mis_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("mis_stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    dmem_gnt = 1'b0;
    applyStimulus(32'h0, 32'h0, 2'b00, 3'b000, 2'b00, 1'b0, 5'd0);
    checkOutput("mis_flag", {31'b0, lsu_misalign}, 32'd1);
    checkOutput("mis_regw", {31'b0, RegW_lsu2wb}, 32'd0);
    tick();
    checkOutput("mis_flag_clear", {31'b0, lsu_misalign}, 32'd0);
`else
    doLoad("lw_mis", 32'h101, 3'b011, 32'hCAFEF00D, 1, 5'd14, 32'hCAFEF00D);
    checkOutput("mis_flag", {31'b0, lsu_misalign}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
